// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
// Holds the coin codes, the coin values in nickels, the FSM state type,
// the inventory struct and small helper functions.
// Optional feature macro: DISP_DOLLAR_EN (dollar coin enable, used by importers).
package change_pkg;

    localparam int unsigned AMT_W  = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned COIN_W = 3;

    typedef logic [COIN_W-1:0] coin_t;

    localparam coin_t COIN_NONE    = 3'b000;
    localparam coin_t COIN_NICKEL  = 3'b001;
    localparam coin_t COIN_DIME    = 3'b010;
    localparam coin_t COIN_QUARTER = 3'b011;
    localparam coin_t COIN_HALF    = 3'b100;
    localparam coin_t COIN_DOLLAR  = 3'b101;

    localparam int unsigned VAL_NICKEL  = 1;
    localparam int unsigned VAL_DIME    = 2;
    localparam int unsigned VAL_QUARTER = 5;
    localparam int unsigned VAL_HALF    = 10;
    localparam int unsigned VAL_DOLLAR  = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Coin inventory, one saturating counter per denomination.
    typedef struct packed {
        logic [CNT_W-1:0] nickel;
        logic [CNT_W-1:0] dime;
        logic [CNT_W-1:0] quarter;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] dollar;
    } coin_counts_t;

    // Value of a coin code in nickels; unknown codes are worth nothing.
    function automatic logic [AMT_W-1:0] coin_value(input coin_t coin);
        case (coin)
            COIN_NICKEL:  return AMT_W'(VAL_NICKEL);
            COIN_DIME:    return AMT_W'(VAL_DIME);
            COIN_QUARTER: return AMT_W'(VAL_QUARTER);
            COIN_HALF:    return AMT_W'(VAL_HALF);
            COIN_DOLLAR:  return AMT_W'(VAL_DOLLAR);
            default:      return '0;
        endcase
    endfunction

    // Decrement that sticks at zero.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the change dispenser and its environment.
// Requests: start, change_amt, restock. Coin handshake: eject_valid,
// eject_coin, eject_ack. Status: busy, done, short, remaining, per-coin
// inventory counts and exact_change.
// Modports: master (environment side), slave (dispenser side).
interface change_dispenser_if;
    import change_pkg::*;

    logic             start;
    logic [AMT_W-1:0] change_amt;
    logic             eject_ack;
    logic             restock;

    logic             busy;
    logic             eject_valid;
    coin_t            eject_coin;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] nickelct;
    logic [CNT_W-1:0] dimect;
    logic [CNT_W-1:0] quarterct;
    logic [CNT_W-1:0] half_dollarct;
    logic [CNT_W-1:0] dollarct;
    logic             exact_change;

    modport master (
        output start, change_amt, eject_ack, restock,
        input  busy, eject_valid, eject_coin, done, short, remaining,
               nickelct, dimect, quarterct, half_dollarct, dollarct, exact_change
    );

    modport slave (
        input  start, change_amt, eject_ack, restock,
        output busy, eject_valid, eject_coin, done, short, remaining,
               nickelct, dimect, quarterct, half_dollarct, dollarct, exact_change
    );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin pick: the largest denomination not exceeding remaining that
// still has stock. Purely combinational.
// Ports: remaining (nickels owed), counts (inventory),
//        found_c (a coin qualifies), coin_c (its code, 000 when none).
// Macro DISP_DOLLAR_EN adds the dollar to the candidate set.
module coin_select
    import change_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    input  coin_counts_t     counts,
    output logic             found_c,
    output coin_t            coin_c
);

    // Candidates checked smallest first so the largest qualifying one wins.
    always_comb begin
        found_c = 1'b0;
        coin_c  = COIN_NONE;
        if (counts.nickel != '0 && remaining >= AMT_W'(VAL_NICKEL)) begin
            found_c = 1'b1;
            coin_c  = COIN_NICKEL;
        end
        if (counts.dime != '0 && remaining >= AMT_W'(VAL_DIME)) begin
            found_c = 1'b1;
            coin_c  = COIN_DIME;
        end
        if (counts.quarter != '0 && remaining >= AMT_W'(VAL_QUARTER)) begin
            found_c = 1'b1;
            coin_c  = COIN_QUARTER;
        end
        if (counts.half != '0 && remaining >= AMT_W'(VAL_HALF)) begin
            found_c = 1'b1;
            coin_c  = COIN_HALF;
        end
`ifdef DISP_DOLLAR_EN
        if (counts.dollar != '0 && remaining >= AMT_W'(VAL_DOLLAR)) begin
            found_c = 1'b1;
            coin_c  = COIN_DOLLAR;
        end
`endif
    end

`ifndef DISP_DOLLAR_EN
    // Dollar stock is always zero in this build and never consulted.
    logic unused_dollar;
    assign unused_dollar = ^counts.dollar;
`endif

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out change_amt nickels one coin at a time using a
// greedy pick over a per-denomination inventory.
// Ports: clk, rst (synchronous, active high), bus (change_dispenser_if.slave).
// Parameters: INIT_COUNT (coins per denomination after reset/restock),
//             EXACT_THRESH (nickel-equivalent threshold for exact_change).
// Macro DISP_DOLLAR_EN enables the dollar coin; otherwise dollarct stays 0.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned INIT_COUNT   = 10,
    parameter int unsigned EXACT_THRESH = 19
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);

    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_COUNT);
`ifdef DISP_DOLLAR_EN
    localparam logic [CNT_W-1:0] INIT_DOLLAR = INIT_CNT;
`else
    localparam logic [CNT_W-1:0] INIT_DOLLAR = '0;
`endif
    localparam coin_counts_t INIT_COUNTS = '{
        nickel: INIT_CNT, dime: INIT_CNT, quarter: INIT_CNT,
        half: INIT_CNT, dollar: INIT_DOLLAR
    };

    // Small-change reserve check: nickels plus dimes in nickel units.
    function automatic logic below_thresh(input coin_counts_t c);
        return (32'(c.nickel) + 32'(c.dime) * 32'd2) < 32'(EXACT_THRESH);
    endfunction

    state_t           state_q, next_state;
    logic             start_q;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    coin_counts_t     counts_q, counts_d;
    logic             eject_valid_q, eject_valid_d;
    coin_t            eject_coin_q, eject_coin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic             exact_q;
    logic             sel_found;
    coin_t            sel_coin;

    coin_select u_coin_select (
        .remaining (remaining_q),
        .counts    (counts_q),
        .found_c   (sel_found),
        .coin_c    (sel_coin)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= next_state;
    end

    // Next-state logic; a zero balance leaves sel_found low and ends the run.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (start_q) next_state = SELECT;
            SELECT:  next_state = sel_found ? EJECT : DONE;
            EJECT:   if (bus.eject_ack) next_state = SELECT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output and datapath next values, registered below.
    always_comb begin
        remaining_d   = remaining_q;
        counts_d      = counts_q;
        eject_coin_d  = COIN_NONE;
        eject_valid_d = (next_state == EJECT);
        busy_d        = (next_state != IDLE);
        done_d        = (next_state == DONE);
        short_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.restock) counts_d = INIT_COUNTS;
                if (start_q)     remaining_d = amt_q;
            end
            SELECT: begin
                if (next_state == EJECT) eject_coin_d = sel_coin;
                else                     short_d = (remaining_q != '0);
            end
            EJECT: begin
                if (bus.eject_ack) begin
                    remaining_d = remaining_q - coin_value(eject_coin_q);
                    case (eject_coin_q)
                        COIN_NICKEL:  counts_d.nickel  = dec_sat(counts_q.nickel);
                        COIN_DIME:    counts_d.dime    = dec_sat(counts_q.dime);
                        COIN_QUARTER: counts_d.quarter = dec_sat(counts_q.quarter);
                        COIN_HALF:    counts_d.half    = dec_sat(counts_q.half);
`ifdef DISP_DOLLAR_EN
                        COIN_DOLLAR:  counts_d.dollar  = dec_sat(counts_q.dollar);
`endif
                        default: ;
                    endcase
                end else begin
                    eject_coin_d = eject_coin_q;
                end
            end
            default: ;
        endcase
    end

    // Registers; start is captured only in IDLE and loses to restock.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q       <= 1'b0;
            amt_q         <= '0;
            remaining_q   <= '0;
            counts_q      <= INIT_COUNTS;
            eject_valid_q <= 1'b0;
            eject_coin_q  <= COIN_NONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            short_q       <= 1'b0;
            exact_q       <= below_thresh(INIT_COUNTS);
        end else begin
            start_q <= bus.start && (state_q == IDLE) && !bus.restock;
            if (bus.start && (state_q == IDLE)) amt_q <= bus.change_amt;
            remaining_q   <= remaining_d;
            counts_q      <= counts_d;
            eject_valid_q <= eject_valid_d;
            eject_coin_q  <= eject_coin_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            short_q       <= short_d;
            exact_q       <= below_thresh(counts_q);
        end
    end

    assign bus.busy          = busy_q;
    assign bus.eject_valid   = eject_valid_q;
    assign bus.eject_coin    = eject_coin_q;
    assign bus.done          = done_q;
    assign bus.short         = short_q;
    assign bus.remaining     = remaining_q;
    assign bus.nickelct      = counts_q.nickel;
    assign bus.dimect        = counts_q.dime;
    assign bus.quarterct     = counts_q.quarter;
    assign bus.half_dollarct = counts_q.half;
    assign bus.dollarct      = counts_q.dollar;
    assign bus.exact_change  = exact_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: dut_a uses default parameters,
// dut_b uses INIT_COUNT=1 to exhaust inventory. Expected coin and done events
// are queued by the stimulus and popped by per-DUT monitors.
// Honours DISP_DOLLAR_EN for the dollar-dependent expectations.
module tb_change_dispenser;
    import change_pkg::*;

`ifdef DISP_DOLLAR_EN
    localparam bit          DOLLAR_ON = 1'b1;
    localparam int unsigned DOL_A     = 10;
    localparam int unsigned DOL_B     = 1;
`else
    localparam bit          DOLLAR_ON = 1'b0;
    localparam int unsigned DOL_A     = 0;
    localparam int unsigned DOL_B     = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if ifa ();
    change_dispenser_if ifb ();

    change_dispenser #(.INIT_COUNT(10), .EXACT_THRESH(19)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    change_dispenser #(.INIT_COUNT(1), .EXACT_THRESH(19)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    typedef struct {
        bit         is_done;
        logic [2:0] coin;
        bit         shrt;
        int         rem;
        int         n, d, q, h, o;
        bit         exact;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic exp_t coin_ev(input logic [2:0] c);
        exp_t e = '{default: 0};
        e.coin = c;
        return e;
    endfunction

    function automatic exp_t done_ev(input bit s, input int rem, input int n, input int d,
                                     input int q, input int h, input int o, input bit ex);
        exp_t e = '{default: 0};
        e.is_done = 1'b1;
        e.shrt = s; e.rem = rem; e.n = n; e.d = d; e.q = q; e.h = h; e.o = o; e.exact = ex;
        return e;
    endfunction

    task automatic observe(input string tag, input exp_t e, input bit is_done,
                           input logic [2:0] coin, input bit shrt, input int rem,
                           input int n, input int d, input int q, input int h, input int o,
                           input bit ex);
        check({tag, "_kind"}, int'(is_done), int'(e.is_done));
        if (!is_done) begin
            check({tag, "_coin"}, int'(coin), int'(e.coin));
        end else begin
            check({tag, "_short"}, int'(shrt), int'(e.shrt));
            check({tag, "_remaining"}, rem, e.rem);
            check({tag, "_nickelct"}, n, e.n);
            check({tag, "_dimect"}, d, e.d);
            check({tag, "_quarterct"}, q, e.q);
            check({tag, "_halfct"}, h, e.h);
            check({tag, "_dollarct"}, o, e.o);
            check({tag, "_exact"}, int'(ex), int'(e.exact));
        end
    endtask

    // Monitors: an accepted coin or a done pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst && ((ifa.eject_valid && ifa.eject_ack) || ifa.done)) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected_event: actual coin=%0d done=%0d, required no event",
                         ifa.eject_coin, ifa.done);
            end else begin
                observe("a", qa.pop_front(), ifa.done, ifa.eject_coin, ifa.short,
                        int'(ifa.remaining), int'(ifa.nickelct), int'(ifa.dimect),
                        int'(ifa.quarterct), int'(ifa.half_dollarct), int'(ifa.dollarct),
                        ifa.exact_change);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ((ifb.eject_valid && ifb.eject_ack) || ifb.done)) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected_event: actual coin=%0d done=%0d, required no event",
                         ifb.eject_coin, ifb.done);
            end else begin
                observe("b", qb.pop_front(), ifb.done, ifb.eject_coin, ifb.short,
                        int'(ifb.remaining), int'(ifb.nickelct), int'(ifb.dimect),
                        int'(ifb.quarterct), int'(ifb.half_dollarct), int'(ifb.dollarct),
                        ifb.exact_change);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dut(input bit b, input logic [7:0] amt);
        tick();
        if (b) begin ifb.change_amt = amt; ifb.start = 1'b1; end
        else   begin ifa.change_amt = amt; ifa.start = 1'b1; end
        tick();
        if (b) ifb.start = 1'b0;
        else   ifa.start = 1'b0;
    endtask

    // Edges after the start-sampling edge until eject_valid or done appears.
    task automatic measure_latency(input string name, input int exp);
        int k = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            tick();
            if (ifa.eject_valid || ifa.done) begin
                seen = 1'b1;
                k = i;
            end
        end
        check(name, k, exp);
    endtask

    task automatic wait_done(input bit b, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = b ? ifb.done : ifa.done;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: actual no done within 200 cycles, required done", name);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h_a;
        int o_a;
        ifa.start = 1'b0; ifa.change_amt = '0; ifa.eject_ack = 1'b1; ifa.restock = 1'b0;
        ifb.start = 1'b0; ifb.change_amt = '0; ifb.eject_ack = 1'b1; ifb.restock = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_eject_valid", int'(ifa.eject_valid), 0);
        check("rst_done", int'(ifa.done), 0);
        check("rst_short", int'(ifa.short), 0);
        check("rst_remaining", int'(ifa.remaining), 0);
        check("rst_eject_coin", int'(ifa.eject_coin), 0);
        check("rst_nickelct", int'(ifa.nickelct), 10);
        check("rst_half_dollarct", int'(ifa.half_dollarct), 10);
        check("rst_dollarct", int'(ifa.dollarct), int'(DOL_A));
        check("rst_exact", int'(ifa.exact_change), 0);
        check("rst_b_quarterct", int'(ifb.quarterct), 1);
        check("rst_b_exact", int'(ifb.exact_change), 1);

        // 7 nickels: quarter then dime.
        qa.push_back(coin_ev(COIN_QUARTER));
        qa.push_back(coin_ev(COIN_DIME));
        qa.push_back(done_ev(1'b0, 0, 10, 9, 9, 10, DOL_A, 1'b0));
        start_dut(1'b0, 8'd7);
        measure_latency("lat_eject", 2);
        wait_done(1'b0, "amt7");

        // Zero change: done two edges after start, no coin.
        qa.push_back(done_ev(1'b0, 0, 10, 9, 9, 10, DOL_A, 1'b0));
        start_dut(1'b0, 8'd0);
        measure_latency("lat_zero_done", 2);
        check("zero_no_eject", int'(ifa.eject_valid), 0);
        tick();

        // Delayed acknowledge: coin held stable, counter drops once.
        ifa.eject_ack = 1'b0;
        qa.push_back(coin_ev(COIN_QUARTER));
        qa.push_back(done_ev(1'b0, 0, 10, 9, 8, 10, DOL_A, 1'b0));
        start_dut(1'b0, 8'd5);
        measure_latency("lat_delayed", 2);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", int'(ifa.eject_valid), 1);
            check("hold_coin", int'(ifa.eject_coin), int'(COIN_QUARTER));
            check("hold_quarterct", int'(ifa.quarterct), 9);
            tick();
        end
        ifa.eject_ack = 1'b1;
        wait_done(1'b0, "delayed");

        // 20 nickels: one dollar, or two halves without the dollar.
        if (DOLLAR_ON) begin
            qa.push_back(coin_ev(COIN_DOLLAR));
            h_a = 10; o_a = 9;
        end else begin
            qa.push_back(coin_ev(COIN_HALF));
            qa.push_back(coin_ev(COIN_HALF));
            h_a = 8; o_a = 0;
        end
        qa.push_back(done_ev(1'b0, 0, 10, 9, 8, h_a, o_a, 1'b0));
        start_dut(1'b0, 8'd20);
        wait_done(1'b0, "amt20");

        // Start while busy is ignored.
        qa.push_back(coin_ev(COIN_DIME));
        qa.push_back(done_ev(1'b0, 0, 10, 8, 8, h_a, o_a, 1'b0));
        start_dut(1'b0, 8'd2);
        ifa.change_amt = 8'd10;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("busy_during_run", int'(ifa.busy), 1);
        wait_done(1'b0, "busy_start");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ignored_start_idle", int'(ifa.busy), 0);
        end

        // Reset in the middle of an eject.
        ifa.eject_ack = 1'b0;
        start_dut(1'b0, 8'd7);
        tick();
        tick();
        check("pre_rst_valid", int'(ifa.eject_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", int'(ifa.eject_valid), 0);
        check("mid_rst_busy", int'(ifa.busy), 0);
        check("mid_rst_remaining", int'(ifa.remaining), 0);
        check("mid_rst_quarterct", int'(ifa.quarterct), 10);
        check("mid_rst_dimect", int'(ifa.dimect), 10);
        check("mid_rst_half_dollarct", int'(ifa.half_dollarct), 10);
        check("mid_rst_dollarct", int'(ifa.dollarct), int'(DOL_A));
        ifa.eject_ack = 1'b1;

        // Deplete a little, then restock together with start: restock wins.
        qa.push_back(coin_ev(COIN_QUARTER));
        qa.push_back(coin_ev(COIN_DIME));
        qa.push_back(done_ev(1'b0, 0, 10, 9, 9, 10, DOL_A, 1'b0));
        start_dut(1'b0, 8'd7);
        wait_done(1'b0, "pre_restock");
        tick();
        ifa.restock = 1'b1;
        ifa.start = 1'b1;
        ifa.change_amt = 8'd5;
        tick();
        ifa.restock = 1'b0;
        ifa.start = 1'b0;
        check("restock_quarterct", int'(ifa.quarterct), 10);
        check("restock_dimect", int'(ifa.dimect), 10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restock_drops_start", int'(ifa.busy), 0);
        end
        check("restock_exact", int'(ifa.exact_change), 0);

        // Single-coin inventory runs dry.
        if (DOLLAR_ON) qb.push_back(coin_ev(COIN_DOLLAR));
        qb.push_back(coin_ev(COIN_HALF));
        qb.push_back(coin_ev(COIN_QUARTER));
        qb.push_back(coin_ev(COIN_DIME));
        qb.push_back(coin_ev(COIN_NICKEL));
        qb.push_back(done_ev(1'b1, DOLLAR_ON ? 12 : 32, 0, 0, 0, 0, 0, 1'b1));
        start_dut(1'b1, 8'd50);
        wait_done(1'b1, "short");
        check("short_remaining_held", int'(ifb.remaining), DOLLAR_ON ? 12 : 32);
        check("short_exact_held", int'(ifb.exact_change), 1);

        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
